y_lsu: RTL and testbench
========================

# y_lsu

- Multi-cycle load/store unit that replaces the single-cycle data-memory stage, downstream of the execute stage (`yEX`) and upstream of write-back (`yWB`).
- Takes the ALU result as the address, `rd2` as store data, and the `MemRead`/`MemWrite`/`funct3` controls.
- Runs one byte/half/word access over a req/ack memory port and returns the sign- or zero-extended load result.
- Asserts `stall` to freeze the PC and register file until the access completes; flags misaligned, illegal and timed-out accesses.

## Interface
Parameters:
- MAX_WAIT, 16: maximum number of BUSY cycles before a bus timeout (≥2).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- MemRead  in  1  load request from control
- MemWrite  in  1  store request from control
- funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- exeOut  in  32  byte address
- rd2  in  32  store data
- memOut  out  32  extended load data, valid in DONE
- stall  out  1  core must hold PC/registers this cycle
- fault  out  1  one-cycle error pulse
- bus_req  out  1  memory request
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address ({exeOut[31:2],2'b00})
- bus_be  out  4  byte enables, little-endian
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  access complete

## Operation
- States: IDLE, BUSY, DONE.

IDLE
- `access = MemRead|MemWrite`.
- Legal access, i.e. all of:
  - not both MemRead and MemWrite;
  - funct3 in {000,001,010,100,101} for loads, {000,001,010} for stores;
  - aligned: h needs exeOut[0]=0, w needs exeOut[1:0]=00.
- Legal access:
  - `stall`=1 combinationally.
  - Register bus_addr/bus_be/bus_wdata/bus_we, the offset exeOut[1:0] and funct3.
  - Clear the wait counter, go to BUSY.
- Illegal access:
  - `fault`=1, `stall`=0, memOut=0 this cycle.
  - No bus activity, stay in IDLE.
- No access: idle; bus_ack is ignored.

BUSY
- bus_req=1; all bus outputs held stable; stall=1.
- bus_ack=1:
  - Capture extended read data into memOut (loads only; stores leave memOut=0).
  - Go to DONE.
- No ack:
  - If counter = MAX_WAIT−1: memOut=0, set a timeout flag, go to DONE.
  - Else counter+1.

DONE
- stall=0, so the core advances at this edge.
- fault=1 iff the timeout flag is set.
- A new access is never accepted here; always return to IDLE.

Lane rules
- b: be=0001<<off, wdata={4{rd2[7:0]}}.
- h: be=0011<<off, wdata={2{rd2[15:0]}}.
- w: be=1111, wdata=rd2.
- Loads: byte = rdata[8·off+7 : 8·off], half = rdata[8·off+15 : 8·off].
- lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend.

## Timing
Reset (rst_n=0 at a clock edge):
- state=IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, memOut=0, fault=0, counter=0.
- stall is forced 0 while rst_n=0.

Latency and handshake
- Minimum latency: request cycle (IDLE) + 1 BUSY + DONE.
- A memory instruction therefore occupies ≥3 cycles; stall is high for ≥2.
- bus_req rises on the edge after the request cycle and falls on the edge after the cycle where bus_ack=1.
- An ack coinciding with the timeout cycle counts as success.

Boundary cases
- Reset mid-BUSY abandons the transaction; bus_req drops at that edge.
- A late bus_ack arriving in IDLE or DONE is ignored.
- Back-to-back memory instructions: the second is seen in IDLE the cycle after DONE; no cycle is lost beyond the DONE cycle.
- Non-memory instructions pass with stall=0 and zero added latency.

## Structure
- Shared package `y_lsu_pkg`:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
  - state enum {IDLE,BUSY,DONE};
  - function for the legality check.
- Sub-module `y_lsu_lane` (combinational):
  - store side: offset+size → bus_be/bus_wdata;
  - load side: offset+size+sign → extended load data.
- FSM and counter stay in `y_lsu`.

## Test plan
- lw at 0x0000_1008, bus_rdata=0xDEADBEEF, ack on first BUSY cycle → bus_be=1111, bus_addr=0x1008, memOut=0xDEADBEEF in DONE, stall high exactly 2 cycles.
- lb at 0x1003, rdata=0x80FF_0011; then lbu at the same address → memOut=0xFFFFFF80, then 0x00000080.
- sh at 0x2002, rd2=0x1234_ABCD, ack after 3 BUSY cycles → bus_we=1, be=1100, wdata=0xABCDABCD held stable 3 cycles; memOut=0.
- lw at 0x1001; then lh at 0x1003; then funct3=011 load → each gives fault pulse same cycle, stall=0, bus_req never asserts.
- MAX_WAIT=16, no ack → bus_req high 16 cycles, DONE with fault=1, memOut=0; ack in the following IDLE is ignored.
- Assert rst_n=0 on the 2nd BUSY cycle → next cycle bus_req=0, state IDLE; following lw completes normally.

Source files
------------

// File: rtl/y_lsu_pkg.sv
// Shared definitions for the multi-cycle load/store unit: funct3 encodings,
// FSM states and the access legality check used in IDLE.
package y_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unsigned sizes exist only for loads; halfwords/words must be naturally aligned.
  function automatic logic access_legal(input logic       rd,
                                        input logic       wr,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic size_ok;
    logic align_ok;
    size_ok  = 1'b0;
    align_ok = 1'b0;
    case (f3)
      F3_B:    begin size_ok = 1'b1; align_ok = 1'b1;            end
      F3_H:    begin size_ok = 1'b1; align_ok = ~off[0];         end
      F3_W:    begin size_ok = 1'b1; align_ok = (off == 2'b00);  end
      F3_BU:   begin size_ok = rd;   align_ok = 1'b1;            end
      F3_HU:   begin size_ok = rd;   align_ok = ~off[0];         end
      default: begin size_ok = 1'b0; align_ok = 1'b0;            end
    endcase
    return (rd ^ wr) & size_ok & align_ok;
  endfunction

endpackage

// File: rtl/y_lsu_lane.sv
// Byte-lane steering: store side builds byte enables and replicated write
// data, load side extracts and extends the addressed byte/half.
module y_lsu_lane
  import y_lsu_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [2:0]  st_f3,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_f3,
  input  logic [31:0] rdata,
  output logic [31:0] ldata
);

  logic [15:0] shifted;

  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    case (st_f3)
      F3_B: begin
        be    = 4'b0001 << st_off;
        wdata = {4{st_data[7:0]}};
      end
      F3_H: begin
        be    = 4'b0011 << st_off;
        wdata = {2{st_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = st_data;
      end
    endcase
  end

  always_comb begin
    shifted = 16'(rdata >> {ld_off, 3'b000});
    ldata   = rdata;
    case (ld_f3)
      F3_B:    ldata = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ldata = {{16{shifted[15]}}, shifted};
      F3_BU:   ldata = {24'b0, shifted[7:0]};
      F3_HU:   ldata = {16'b0, shifted};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/y_lsu.sv
// Multi-cycle load/store unit between execute and write-back: one req/ack
// memory access per instruction, stalling the core until it completes.
module y_lsu
  import y_lsu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] exeOut,
  input  logic [31:0] rd2,
  output logic [31:0] memOut,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int unsigned   CW   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic          rd_q;
  logic          tmo;

  logic          access;
  logic          legal;
  logic [3:0]    be_n;
  logic [31:0]   wdata_n;
  logic [31:0]   ldata;

  assign access = MemRead | MemWrite;
  assign legal  = access_legal(MemRead, MemWrite, funct3, exeOut[1:0]);

  y_lsu_lane u_lane (
    .st_off  (exeOut[1:0]),
    .st_f3   (funct3),
    .st_data (rd2),
    .be      (be_n),
    .wdata   (wdata_n),
    .ld_off  (off_q),
    .ld_f3   (f3_q),
    .rdata   (bus_rdata),
    .ldata   (ldata)
  );

  // stall/fault must react in the request cycle itself, so they stay combinational.
  always_comb begin
    stall = 1'b0;
    fault = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          stall = access & legal;
          fault = access & ~legal;
        end
        BUSY:    stall = 1'b1;
        DONE:    fault = tmo;
        default: begin
          stall = 1'b0;
          fault = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      off_q     <= '0;
      f3_q      <= '0;
      rd_q      <= 1'b0;
      tmo       <= 1'b0;
      memOut    <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access && legal) begin
            state     <= BUSY;
            cnt       <= '0;
            tmo       <= 1'b0;
            off_q     <= exeOut[1:0];
            f3_q      <= funct3;
            rd_q      <= MemRead;
            bus_req   <= 1'b1;
            bus_we    <= MemWrite;
            bus_addr  <= {exeOut[31:2], 2'b00};
            bus_be    <= be_n;
            bus_wdata <= wdata_n;
          end
        end
        BUSY: begin
          // An ack in the final wait cycle wins over the timeout.
          if (bus_ack) begin
            memOut  <= rd_q ? ldata : '0;
            bus_req <= 1'b0;
            state   <= DONE;
          end else if (cnt == LAST) begin
            memOut  <= '0;
            tmo     <= 1'b1;
            bus_req <= 1'b0;
            state   <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          memOut <= '0;
          tmo    <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y_lsu.sv
// Directed self-checking bench for y_lsu with hand-computed expectations.
module tb_y_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] exeOut, rd2;
  logic [31:0] memOut;
  logic        stall, fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Results gathered by do_access
  logic [31:0] r_mem, r_wdata, r_addr;
  logic [3:0]  r_be;
  logic        r_we, r_fault, r_stable, r_to;
  int          r_stall, r_req;

  y_lsu #(.MAX_WAIT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .funct3    (funct3),
    .exeOut    (exeOut),
    .rd2       (rd2),
    .memOut    (memOut),
    .stall     (stall),
    .fault     (fault),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Runs one access: request cycle, BUSY cycles (ack on BUSY index ack_at, -1 = never), DONE.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rdat, input int ack_at);
    int k;
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; funct3 = f3; exeOut = a; rd2 = d; bus_ack = 1'b0;
    #1;
    r_stall = int'(stall); r_req = 0; r_stable = 1'b1; r_to = 1'b1;
    r_mem = 'x; r_fault = 1'bx;
    k = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!bus_req) begin
        r_mem = memOut; r_fault = fault; r_stall += int'(stall); r_to = 1'b0;
        break;
      end
      bus_ack = (k == ack_at); bus_rdata = rdat;
      #1;
      if (k == 0) begin
        r_be = bus_be; r_wdata = bus_wdata; r_addr = bus_addr; r_we = bus_we;
      end else if (bus_be !== r_be || bus_wdata !== r_wdata || bus_addr !== r_addr || bus_we !== r_we) begin
        r_stable = 1'b0;
      end
      r_req++; r_stall += int'(stall); k++;
    end
    bus_ack = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(posedge clk); #1;
    MemRead = 1'b1; funct3 = 3'b010; exeOut = 32'h100;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    @(posedge clk); #1;
    checks++; if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_be !== 4'h0) begin errors++; $display("FAIL reset_bus req=%b we=%b be=%h want 0", bus_req, bus_we, bus_be); end
    checks++; if (bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_addr addr=%h wdata=%h want 0", bus_addr, bus_wdata); end
    checks++; if (memOut !== 32'h0 || fault !== 1'b0) begin errors++; $display("FAIL reset_out mem=%h fault=%b want 0", memOut, fault); end
    MemRead = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_lw;
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_1008, 32'h0, 32'hDEAD_BEEF, 0);
    checks++; if (r_to !== 1'b0) begin errors++; $display("FAIL lw_done got timeout=%b want 0", r_to); end
    checks++; if (r_mem !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data got %h want deadbeef", r_mem); end
    checks++; if (r_be !== 4'b1111 || r_addr !== 32'h1008 || r_we !== 1'b0) begin errors++; $display("FAIL lw_bus be=%b addr=%h we=%b want 1111 1008 0", r_be, r_addr, r_we); end
    checks++; if (r_stall != 2) begin errors++; $display("FAIL lw_stall got %0d want 2", r_stall); end
    checks++; if (r_req != 1 || r_fault !== 1'b0) begin errors++; $display("FAIL lw_req req=%0d fault=%b want 1 0", r_req, r_fault); end
    @(posedge clk); #1;
    checks++; if (memOut !== 32'h0 || stall !== 1'b0) begin errors++; $display("FAIL lw_idle mem=%h stall=%b want 0 0", memOut, stall); end
  endtask

  task automatic test_lb_lbu;
    do_access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0011, 0);
    checks++; if (r_mem !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", r_mem); end
    checks++; if (r_be !== 4'b1000) begin errors++; $display("FAIL lb_be got %b want 1000", r_be); end
    do_access(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_0011, 0);
    checks++; if (r_mem !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got %h want 00000080", r_mem); end
    do_access(1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h80FF_0011, 1);
    checks++; if (r_mem !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_data got %h want ffff80ff", r_mem); end
    do_access(1'b1, 1'b0, 3'b101, 32'h0000_1002, 32'h0, 32'h80FF_0011, 0);
    checks++; if (r_mem !== 32'h0000_80FF) begin errors++; $display("FAIL lhu_data got %h want 000080ff", r_mem); end
    do_access(1'b1, 1'b0, 3'b101, 32'h0000_1000, 32'h0, 32'h80FF_0011, 0);
    checks++; if (r_mem !== 32'h0000_0011) begin errors++; $display("FAIL lhu_lo got %h want 00000011", r_mem); end
  endtask

  task automatic test_stores;
    do_access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 2);
    checks++; if (r_we !== 1'b1 || r_be !== 4'b1100) begin errors++; $display("FAIL sh_bus we=%b be=%b want 1 1100", r_we, r_be); end
    checks++; if (r_wdata !== 32'hABCD_ABCD || r_addr !== 32'h2000) begin errors++; $display("FAIL sh_wdata wdata=%h addr=%h want abcdabcd 2000", r_wdata, r_addr); end
    checks++; if (r_req != 3 || r_stable !== 1'b1) begin errors++; $display("FAIL sh_hold req=%0d stable=%b want 3 1", r_req, r_stable); end
    checks++; if (r_mem !== 32'h0 || r_stall != 4) begin errors++; $display("FAIL sh_done mem=%h stall=%0d want 0 4", r_mem, r_stall); end
    do_access(1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'hCAFE_0055, 32'h0, 0);
    checks++; if (r_be !== 4'b0010 || r_wdata !== 32'h5555_5555) begin errors++; $display("FAIL sb_bus be=%b wdata=%h want 0010 55555555", r_be, r_wdata); end
    do_access(1'b0, 1'b1, 3'b010, 32'h0000_3004, 32'h0102_0304, 32'h0, 0);
    checks++; if (r_be !== 4'b1111 || r_wdata !== 32'h0102_0304) begin errors++; $display("FAIL sw_bus be=%b wdata=%h want 1111 01020304", r_be, r_wdata); end
  endtask

  task automatic test_illegal;
    logic [31:0] ta [4];
    logic [2:0]  tf [4];
    logic        tw [4];
    ta = '{32'h1001, 32'h1003, 32'h1000, 32'h1000};
    tf = '{3'b010, 3'b001, 3'b011, 3'b100};
    tw = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      MemRead = ~tw[i]; MemWrite = tw[i]; funct3 = tf[i]; exeOut = ta[i];
      #1;
      checks++; if (fault !== 1'b1 || stall !== 1'b0 || memOut !== 32'h0) begin errors++; $display("FAIL illegal_%0d fault=%b stall=%b mem=%h want 1 0 0", i, fault, stall, memOut); end
      @(posedge clk); #1;
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL illegal_req_%0d got %b want 0", i, bus_req); end
      MemRead = 1'b0; MemWrite = 1'b0;
    end
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 1'b1; funct3 = 3'b010; exeOut = 32'h1000;
    #1;
    checks++; if (fault !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL illegal_rw fault=%b stall=%b want 1 0", fault, stall); end
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic test_timeout;
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h1111_1111, -1);
    checks++; if (r_req != 16 || r_to !== 1'b0) begin errors++; $display("FAIL tmo_req got %0d (stuck=%b) want 16", r_req, r_to); end
    checks++; if (r_fault !== 1'b1 || r_mem !== 32'h0) begin errors++; $display("FAIL tmo_done fault=%b mem=%h want 1 0", r_fault, r_mem); end
    bus_ack = 1'b1; bus_rdata = 32'h2222_2222;
    @(posedge clk); #1;
    checks++; if (stall !== 1'b0 || fault !== 1'b0 || memOut !== 32'h0) begin errors++; $display("FAIL tmo_idle stall=%b fault=%b mem=%h want 0 0 0", stall, fault, memOut); end
    @(posedge clk); #1;
    checks++; if (bus_req !== 1'b0 || memOut !== 32'h0) begin errors++; $display("FAIL late_ack req=%b mem=%h want 0 0", bus_req, memOut); end
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_4004, 32'h0, 32'h3333_3333, 15);
    checks++; if (r_req != 16 || r_fault !== 1'b0 || r_mem !== 32'h3333_3333) begin errors++; $display("FAIL ack_last req=%0d fault=%b mem=%h want 16 0 33333333", r_req, r_fault, r_mem); end
  endtask

  task automatic test_reset_busy;
    @(posedge clk); #1;
    MemRead = 1'b1; funct3 = 3'b010; exeOut = 32'h3000;
    @(posedge clk); #1;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rb_busy got %b want 1", bus_req); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rb_stall got %b want 0", stall); end
    @(posedge clk); #1;
    checks++; if (bus_req !== 1'b0 || bus_be !== 4'h0 || memOut !== 32'h0) begin errors++; $display("FAIL rb_abort req=%b be=%h mem=%h want 0 0 0", bus_req, bus_be, memOut); end
    rst_n = 1'b1; MemRead = 1'b0;
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_3004, 32'h0, 32'h0BAD_F00D, 0);
    checks++; if (r_mem !== 32'h0BAD_F00D || r_req != 1) begin errors++; $display("FAIL rb_after mem=%h req=%0d want 0badf00d 1", r_mem, r_req); end
  endtask

  task automatic test_back_to_back;
    int c1;
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'hAAAA_5555, 0);
    c1 = cyc;
    do_access(1'b1, 1'b0, 3'b000, 32'h0000_5001, 32'h0, 32'hAAAA_5555, 0);
    checks++; if (cyc - c1 != 3) begin errors++; $display("FAIL b2b_cycles got %0d want 3", cyc - c1); end
    checks++; if (r_mem !== 32'h0000_0055) begin errors++; $display("FAIL b2b_data got %h want 00000055", r_mem); end
  endtask

  task automatic test_nonmem;
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0; bus_ack = 1'b1; exeOut = 32'h1001;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall !== 1'b0 || fault !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL nonmem_%0d stall=%b fault=%b req=%b want 0 0 0", i, stall, fault, bus_req); end
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b0;
    exeOut = '0; rd2 = '0; bus_rdata = '0; bus_ack = 1'b0;
    test_reset;
    test_lw;
    test_lb_lbu;
    test_stores;
    test_illegal;
    test_timeout;
    test_reset_busy;
    test_back_to_back;
    test_nonmem;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
